// File: rtl/dram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dram_pkg
//  Description : Shared definitions for the DRAM responder model: controller
//                state encoding, default geometry, refresh counter width and
//                a small width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package dram_pkg;

    localparam int ROW_W_DEF     = 4;
    localparam int COL_W_DEF     = 4;
    localparam int DATA_W_DEF    = 8;
    localparam int REFRESH_CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ROW    = 3'd1,
        S_ACCESS = 3'd2,
        S_CBR    = 3'd3,
        S_WAIT   = 3'd4
    } state_t;

    // Width of the multiplexed address bus.
    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dram_lat_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : dram_lat_pipe
//  Description : CAS latency pipeline. A read strobe and the array output
//                enter stage 0 and emerge CAS_LAT cycles later as a one-cycle
//                dout_valid pulse. Each stage only captures data when its
//                incoming valid is set, so dout holds the last read value
//                until the next read replaces it.
//  Ports       : clk        - system clock
//                reset_n    - asynchronous active-low reset
//                rd_stb     - read issued this cycle
//                rd_data    - array data for the issued read
//                dout       - read data (held)
//                dout_valid - one-cycle pulse per completed read
//  Revision    : 1.0  initial release
// ============================================================================
module dram_lat_pipe #(
    parameter int CAS_LAT = 1,   // legal range 1..4
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rd_stb,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid
);

    logic              r_vld [CAS_LAT];
    logic [DATA_W-1:0] r_dat [CAS_LAT];

    for (genvar gi = 0; gi < CAS_LAT; gi++) begin : g_stage
        logic              w_v_in;
        logic [DATA_W-1:0] w_d_in;

        if (gi == 0) begin : g_head
            assign w_v_in = rd_stb;
            assign w_d_in = rd_data;
        end else begin : g_tail
            assign w_v_in = r_vld[gi-1];
            assign w_d_in = r_dat[gi-1];
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_vld[gi] <= 1'b0;
                r_dat[gi] <= '0;
            end else begin
                r_vld[gi] <= w_v_in;
                if (w_v_in) begin
                    r_dat[gi] <= w_d_in;
                end
            end
        end
    end

    assign dout       = r_dat[CAS_LAT-1];
    assign dout_valid = r_vld[CAS_LAT-1];

endmodule
`default_nettype wire

// File: rtl/dram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dram_responder
//  Description : Cycle-sampled DRAM device model. Decodes the RAS/CAS strobe
//                sequence, demultiplexes row/column from the shared address
//                bus, writes/reads an internal array, returns read data after
//                CAS_LAT cycles, counts CAS-before-RAS refreshes and pulses
//                proto_err on malformed sequences.
//  Ports       : clk         - system clock, inputs sampled on rising edge
//                reset_n     - asynchronous active-low reset
//                ras, cas    - row / column strobes, active low
//                mux         - controller address select (checking only)
//                addr        - multiplexed row/column address
//                we, din     - write enable / data, sampled at CAS fall
//                dout        - read data
//                dout_valid  - one-cycle pulse per read
//                refresh_cnt - CBR refresh count (wraps)
//                proto_err   - one-cycle pulse on an illegal sequence
//  Revision    : 1.0  initial release
// ============================================================================
module dram_responder
    import dram_pkg::*;
#(
    parameter int ROW_W   = ROW_W_DEF,
    parameter int COL_W   = COL_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CAS_LAT = 1            // legal range 1..4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           ras,
    input  logic                           cas,
    input  logic                           mux,
    input  logic [max_w(ROW_W,COL_W)-1:0]  addr,
    input  logic                           we,
    input  logic [DATA_W-1:0]              din,
    output logic [DATA_W-1:0]              dout,
    output logic                           dout_valid,
    output logic [REFRESH_CNT_W-1:0]       refresh_cnt,
    output logic                           proto_err
);

    localparam int c_DEPTH = 1 << (ROW_W + COL_W);

    // ------------------------------------------------------------------
    // Strobe edge detection (previous samples reset to the idle level)
    // ------------------------------------------------------------------
    logic r_ras_q;
    logic r_cas_q;
    logic w_ras_fall;
    logic w_ras_rise;
    logic w_cas_fall;
    logic w_cas_rise;

    assign w_ras_fall = r_ras_q & ~ras;
    assign w_ras_rise = ~r_ras_q & ras;
    assign w_cas_fall = r_cas_q & ~cas;
    assign w_cas_rise = ~r_cas_q & cas;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [ROW_W-1:0]         r_row;
    logic [COL_W-1:0]         r_col;
    logic [REFRESH_CNT_W-1:0] r_refresh_cnt;
    logic                     r_proto_err;

    logic w_row_ld;
    logic w_access;
    logic w_err;
    logic w_ref_inc;

    // ------------------------------------------------------------------
    // Next-state / control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_row_ld    = 1'b0;
        w_access    = 1'b0;
        w_err       = 1'b0;
        w_ref_inc   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_ras_fall && cas) begin
                    w_row_ld    = 1'b1;
                    w_state_nxt = S_ROW;
                end else if (w_ras_fall && !cas) begin
                    // RAS and CAS low together: no way to tell row from refresh
                    w_err       = 1'b1;
                    w_state_nxt = S_WAIT;
                end else if (w_cas_fall && ras) begin
                    w_state_nxt = S_CBR;
                end
            end

            S_ROW: begin
                if (w_ras_rise) begin
                    // Row opened and closed without a column access
                    w_state_nxt = S_IDLE;
                end else if (w_cas_fall) begin
                    w_access    = 1'b1;
                    w_err       = ~mux;   // controller still driving the row
                    w_state_nxt = S_ACCESS;
                end
            end

            S_ACCESS: begin
                if (w_ras_rise) begin
                    w_state_nxt = S_IDLE;
                end else if (w_cas_rise) begin
                    // Page mode: row stays open for another column
                    w_state_nxt = S_ROW;
                end
            end

            S_CBR: begin
                if (w_ras_fall) begin
                    w_ref_inc   = 1'b1;
                    w_state_nxt = S_WAIT;
                end else if (w_cas_rise) begin
                    w_err       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end

            S_WAIT: begin
                if (ras && cas) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ras_q       <= 1'b1;
            r_cas_q       <= 1'b1;
            r_state       <= S_IDLE;
            r_row         <= '0;
            r_col         <= '0;
            r_refresh_cnt <= '0;
            r_proto_err   <= 1'b0;
        end else begin
            r_ras_q     <= ras;
            r_cas_q     <= cas;
            r_state     <= w_state_nxt;
            r_proto_err <= w_err;
            if (w_row_ld) begin
                r_row <= addr[ROW_W-1:0];
            end
            if (w_access) begin
                r_col <= addr[COL_W-1:0];
            end
            if (w_ref_inc) begin
                r_refresh_cnt <= r_refresh_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Array. The access cycle uses the column straight off the bus, since
    // the column register only captures it at the end of that cycle;
    // otherwise the read port keeps pointing at the open column.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]      r_mem [c_DEPTH];
    logic [COL_W-1:0]       w_col;
    logic [ROW_W+COL_W-1:0] w_idx;
    logic                   w_wr;
    logic                   w_rd;
    logic [DATA_W-1:0]      w_rd_data;

    assign w_col     = w_access ? addr[COL_W-1:0] : r_col;
    assign w_idx     = {r_row, w_col};
    assign w_wr      = w_access & we;
    assign w_rd      = w_access & ~we;
    assign w_rd_data = r_mem[w_idx];

    // Under reset the FSM sits in S_IDLE, so no write can be committed.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[w_idx] <= din;
        end
    end

    // ------------------------------------------------------------------
    // Read latency pipeline
    // ------------------------------------------------------------------
    dram_lat_pipe #(
        .CAS_LAT (CAS_LAT),
        .DATA_W  (DATA_W)
    ) u_lat_pipe (
        .clk        (clk),
        .reset_n    (reset_n),
        .rd_stb     (w_rd),
        .rd_data    (w_rd_data),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    assign refresh_cnt = r_refresh_cnt;
    assign proto_err   = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_dram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dram_responder
//  Description : Scoreboard bench for dram_responder. Two instances share the
//                strobes: one with CAS_LAT = 1 and one with CAS_LAT = 3 (own
//                reset, used for the reset-mid-read case). Expected read data
//                is queued per instance when a read CAS fall is issued; a
//                monitor pops and compares on every dout_valid pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dram_responder;
    import dram_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rst3_n;
    logic       ras;
    logic       cas;
    logic       mux;
    logic [3:0] addr;
    logic       we;
    logic [7:0] din;

    logic [7:0]  dout1, dout3;
    logic        dv1, dv3;
    logic [15:0] rc1, rc3;
    logic        pe1, pe3;

    always #5 clk = ~clk;

    dram_responder #(.ROW_W(4), .COL_W(4), .DATA_W(8), .CAS_LAT(1)) u_dut (
        .clk(clk), .reset_n(rst_n), .ras(ras), .cas(cas), .mux(mux),
        .addr(addr), .we(we), .din(din), .dout(dout1), .dout_valid(dv1),
        .refresh_cnt(rc1), .proto_err(pe1)
    );

    dram_responder #(.ROW_W(4), .COL_W(4), .DATA_W(8), .CAS_LAT(3)) u_dut3 (
        .clk(clk), .reset_n(rst3_n), .ras(ras), .cas(cas), .mux(mux),
        .addr(addr), .we(we), .din(din), .dout(dout3), .dout_valid(dv3),
        .refresh_cnt(rc3), .proto_err(pe3)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    logic [7:0] q1[$];
    logic [7:0] q3[$];
    int n_chk  = 0;
    int n_pass = 0;
    int n_pe1  = 0;
    int n_pe3  = 0;
    int n_dv3  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        logic [7:0] e;
        if (pe1) n_pe1++;
        if (pe3) n_pe3++;
        if (dv3) n_dv3++;
        if (dv1) begin
            n_chk++;
            if (q1.size() == 0) begin
                $display("FAIL dout1_unexpected: got 0x%0h expected no read", dout1);
            end else begin
                e = q1.pop_front();
                if (dout1 === e) n_pass++;
                else $display("FAIL dout1: got 0x%0h expected 0x%0h", dout1, e);
            end
        end
        if (dv3) begin
            n_chk++;
            if (q3.size() == 0) begin
                $display("FAIL dout3_unexpected: got 0x%0h expected no read", dout3);
            end else begin
                e = q3.pop_front();
                if (dout3 === e) n_pass++;
                else $display("FAIL dout3: got 0x%0h expected 0x%0h", dout3, e);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: one call = one sampled cycle
    // ------------------------------------------------------------------
    task automatic cyc(input logic r, input logic m, input logic c,
                       input logic [3:0] a, input logic w, input logic [7:0] d);
        ras = r; mux = m; cas = c; addr = a; we = w; din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 8'h00);
    endtask

    task automatic wr(input logic [3:0] row, input logic [3:0] col, input logic [7:0] d);
        idle();
        cyc(1'b0, 1'b0, 1'b1, row, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b1, col, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, col, 1'b1, d);
        cyc(1'b0, 1'b1, 1'b0, col, 1'b0, 8'h00);
        idle();
    endtask

    task automatic rd(input logic [3:0] row, input logic [3:0] col, input logic [7:0] exp);
        idle();
        cyc(1'b0, 1'b0, 1'b1, row, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b1, col, 1'b0, 8'h00);
        q1.push_back(exp);
        q3.push_back(exp);
        cyc(1'b0, 1'b1, 1'b0, col, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, col, 1'b0, 8'h00);
        idle();
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int pe1_0, pe3_0, dv3_0;
        logic [7:0] pd [4];
        pd[0] = 8'h10; pd[1] = 8'h11; pd[2] = 8'h12; pd[3] = 8'h13;

        rst_n = 1'b0; rst3_n = 1'b0;
        ras = 1'b1; cas = 1'b1; mux = 1'b0; addr = 4'h0; we = 1'b0; din = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dv1",   32'(dv1),   32'h0);
        chk("rst_dout1", 32'(dout1), 32'h0);
        chk("rst_rc1",   32'(rc1),   32'h0);
        chk("rst_pe1",   32'(pe1),   32'h0);
        chk("rst_dv3",   32'(dv3),   32'h0);
        chk("rst_rc3",   32'(rc3),   32'h0);
        chk("rst_state", 32'(u_dut.r_state), 32'(S_IDLE));
        rst_n = 1'b1; rst3_n = 1'b1;
        idle();

        // Write then read, row 3 col 5
        wr(4'd3, 4'd5, 8'hA5);
        rd(4'd3, 4'd5, 8'hA5);

        // Page mode on row 2: four writes, then one RAS-low period, four CAS
        for (int c = 0; c < 4; c++) wr(4'd2, 4'(c), pd[c]);
        idle();
        cyc(1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 8'h00);
        for (int c = 0; c < 4; c++) begin
            cyc(1'b0, 1'b1, 1'b1, 4'(c), 1'b0, 8'h00);
            q1.push_back(pd[c]);
            q3.push_back(pd[c]);
            cyc(1'b0, 1'b1, 1'b0, 4'(c), 1'b0, 8'h00);
        end
        cyc(1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 8'h00);
        idle();
        repeat (3) idle();

        // CBR refresh x3
        pe1_0 = n_pe1; pe3_0 = n_pe3;
        for (int i = 0; i < 3; i++) begin
            idle();
            cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00);
            cyc(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00);
            cyc(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00);
            idle();
        end
        idle();
        chk("cbr_rc1", 32'(rc1), 32'd3);
        chk("cbr_rc3", 32'(rc3), 32'd3);
        chk("cbr_no_perr1", 32'(n_pe1), 32'(pe1_0));
        chk("cbr_no_perr3", 32'(n_pe3), 32'(pe3_0));
        rd(4'd2, 4'd1, 8'h11);

        // RAS and CAS fall together: error, S_WAIT, no write
        pe1_0 = n_pe1;
        idle();
        cyc(1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 8'hFF);
        chk("same_state", 32'(u_dut.r_state), 32'(S_WAIT));
        cyc(1'b0, 1'b1, 1'b0, 4'd5, 1'b1, 8'hFF);
        idle();
        idle();
        chk("same_perr", 32'(n_pe1), 32'(pe1_0 + 1));
        chk("same_idle", 32'(u_dut.r_state), 32'(S_IDLE));
        chk("same_rc1",  32'(rc1), 32'd3);
        rd(4'd3, 4'd5, 8'hA5);

        // CAS fall with mux = 0: error, but the write still lands
        pe1_0 = n_pe1; pe3_0 = n_pe3;
        idle();
        cyc(1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 4'd7, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 4'd7, 1'b1, 8'h5C);
        cyc(1'b0, 1'b0, 1'b0, 4'd7, 1'b0, 8'h00);
        idle();
        chk("mux0_perr1", 32'(n_pe1), 32'(pe1_0 + 1));
        chk("mux0_perr3", 32'(n_pe3), 32'(pe3_0 + 1));
        rd(4'd1, 4'd7, 8'h5C);

        // Aborted row: no error, back to idle, array untouched
        pe1_0 = n_pe1;
        idle();
        cyc(1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 8'h77);
        cyc(1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 8'h77);
        idle();
        chk("abort_state", 32'(u_dut.r_state), 32'(S_IDLE));
        idle();
        chk("abort_perr", 32'(n_pe1), 32'(pe1_0));
        rd(4'd3, 4'd5, 8'hA5);
        repeat (4) idle();

        // Reset the CAS_LAT=3 instance one cycle after a read CAS fall
        dv3_0 = n_dv3;
        idle();
        cyc(1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b1, 4'd2, 1'b0, 8'h00);
        q1.push_back(8'h12);
        cyc(1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 8'h00);
        rst3_n = 1'b0;
        #1;
        chk("rst3_dv",   32'(dv3),   32'h0);
        chk("rst3_dout", 32'(dout3), 32'h0);
        chk("rst3_rc",   32'(rc3),   32'h0);
        chk("rst3_pe",   32'(pe3),   32'h0);
        cyc(1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 8'h00);
        repeat (4) idle();
        chk("rst3_no_valid", 32'(n_dv3), 32'(dv3_0));
        rst3_n = 1'b1;
        idle();
        rd(4'd2, 4'd3, 8'h13);
        repeat (6) idle();

        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("q3_drained", 32'(q3.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
